calc_sequencer: RTL

Controller that steps the calculation datapath one operation per NEXT button press. It conditions the raw NEXT button with a synchronizer, a debouncer and an edge detector. On each press it fetches an operand pair from an external table via idx, runs a sequential shift-add multiply, and presents the 16-bit result on producto. It sits between the board button and the product display path, and it owns the operand index.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/shift_add_mult.sv | 75 +++++++
 rtl/calc_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared types and default sizing for the calculation sequencer.
//   state_t              : sequencer state encoding (IDLE, LOAD, MUL, SHOW)
//   CALC_WIDTH           : default operand width
//   CALC_N_ENTRIES       : default operand-table depth
//   CALC_DEBOUNCE_CYCLES : default stable-sample count for the button
//   idx_w()              : index width for a given table depth
// ----------------------------------------------------------------------------
package calc_pkg;

  localparam int unsigned CALC_WIDTH           = 8;
  localparam int unsigned CALC_N_ENTRIES       = 4;
  localparam int unsigned CALC_DEBOUNCE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MUL  = 2'd2,
    SHOW = 2'd3
  } state_t;

  // A one-entry table still needs a 1-bit index port.
  function automatic int unsigned idx_w(input int unsigned n_entries);
    return (n_entries > 1) ? $clog2(n_entries) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_w(CALC_N_ENTRIES);

endpackage : calc_pkg

// File: rtl/shift_add_mult.sv
// ----------------------------------------------------------------------------
// shift_add_mult
// Sequential unsigned WIDTH x WIDTH shift-add multiplier.
//   clk   : clock
//   rst   : asynchronous active-low reset, aborts any operation in flight
//   start : 1-cycle request; a and b are sampled on this edge
//   a, b  : multiplicand / multiplier
//   done  : high for one cycle once p holds the complete product
//   p     : product (accumulator)
// The first partial product is folded into the start edge, so with start
// issued in cycle s the last iteration completes at the end of cycle
// s+WIDTH-1 and done/p are valid in cycle s+WIDTH. The caller can then
// capture p with a register on that same edge.
// ----------------------------------------------------------------------------
module shift_add_mult
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic             r_done;

  // Iteration engine: r_cnt counts partial products already accumulated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_acc    <= b[0] ? PW'(a) : '0;
      r_mcand  <= PW'(a) << 1;
      r_mplier <= b >> 1;
      r_cnt    <= CNT_W'(1);
      r_run    <= (WIDTH > 1);
      r_done   <= (WIDTH == 1);
    end else if (r_run) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
      // This edge accumulates the final partial product.
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done = r_done;
  assign p    = r_acc;

endmodule : shift_add_mult

// File: rtl/calc_sequencer.sv
// ----------------------------------------------------------------------------
// calc_sequencer
// Steps the calculation datapath one multiply per NEXT button press.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   NEXT     : raw, bouncing, asynchronous button
//   a_in     : operand A from the external table at idx (sampled in LOAD)
//   b_in     : operand B from the external table at idx (sampled in LOAD)
//   idx      : current table index, wraps at N_ENTRIES-1
//   producto : last completed unsigned product
//   valid    : producto holds the result for the current idx
//   busy     : high in LOAD and MUL
// Presses arriving while busy are dropped.
// ----------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH           = CALC_WIDTH,
  parameter int unsigned N_ENTRIES       = CALC_N_ENTRIES,
  parameter int unsigned DEBOUNCE_CYCLES = CALC_DEBOUNCE_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         NEXT,
  input  logic [WIDTH-1:0]             a_in,
  input  logic [WIDTH-1:0]             b_in,
  output logic [idx_w(N_ENTRIES)-1:0]  idx,
  output logic [2*WIDTH-1:0]           producto,
  output logic                         valid,
  output logic                         busy
);

  localparam int unsigned IW   = idx_w(N_ENTRIES);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Button conditioning
  logic            r_sync1;
  logic            r_sync2;
  logic            r_db;
  logic            r_db_q;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_press;

  // Sequencer
  state_t             r_state;
  logic [IW-1:0]      r_idx;
  logic [2*WIDTH-1:0] r_producto;
  logic               r_valid;
  logic               r_busy;

  // Multiplier interface
  logic               w_start;
  logic               w_done;
  logic [2*WIDTH-1:0] w_p;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= NEXT;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a level change only after DEBOUNCE_CYCLES consecutive
  // synchronized samples that disagree with the current level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db     <= 1'b0;
      r_db_q   <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_db_q <= r_db;
      if (r_sync2 != r_db) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db     <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // One-cycle pulse on the debounced rising edge.
  assign w_press = r_db & ~r_db_q;

  assign w_start = (r_state == LOAD);

  shift_add_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .a     (a_in),
    .b     (b_in),
    .done  (w_done),
    .p     (w_p)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_producto <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        LOAD: begin
          r_state <= MUL;
        end
        MUL: begin
          if (w_done) begin
            r_state    <= SHOW;
            r_producto <= w_p;
            r_valid    <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        SHOW: begin
          if (w_press) begin
            r_idx   <= (r_idx == IW'(N_ENTRIES - 1)) ? '0 : r_idx + IW'(1);
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign idx      = r_idx;
  assign producto = r_producto;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule : calc_sequencer
